// File: rtl/tmds_pll_rst_seq.sv
// -----------------------------------------------------------------------------
// tmds_pll_rst_seq
//
// Reset/lock sequencer for the TMDS PLL (27 MHz in, 124.875 MHz serial out).
// Pulses the PLL reset, qualifies the PLL lock and then releases the
// serializer reset followed by the video-timing reset. A lock timeout
// retries the PLL, up to MAX_RETRY attempts, before parking in FAIL. A lock
// loss after qualification tears the pipeline down and starts over. The
// block runs only on the 27 MHz board clock, which is valid whatever the
// PLL is doing.
//
// Ports:
//   sys_clk    in   27 MHz board clock, the only clock
//   rst_n      in   asynchronous active-low reset
//   pll_lock   in   PLL LOCK, asynchronous; double-flopped to lock_s
//   restart    in   single-cycle synchronous request to rerun the sequence
//   pll_reset  out  active-high PLL reset
//   ser_rst_n  out  serializer reset, active low (re-synchronized by consumer)
//   vid_rst_n  out  video timing/pattern reset, active low
//   locked     out  pipeline running
//   fail       out  lock retries exhausted
//   retry_cnt  out  lock timeouts since the last clear
//
// All outputs are registered and decoded from the next state, so they move
// on the same edge as the state register.
// -----------------------------------------------------------------------------
module tmds_pll_rst_seq #(
   parameter int RST_PULSE_CYC    = 27,
   parameter int LOCK_STABLE_CYC  = 2700,
   parameter int LOCK_TIMEOUT_CYC = 270000,
   parameter int MAX_RETRY        = 3,
   parameter int SER_TO_VID_CYC   = 16
) (
   input  logic                           sys_clk,
   input  logic                           rst_n,
   input  logic                           pll_lock,
   input  logic                           restart,
   output logic                           pll_reset,
   output logic                           ser_rst_n,
   output logic                           vid_rst_n,
   output logic                           locked,
   output logic                           fail,
   output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

   // The shared cycle counter times the reset pulse, the lock-stable window
   // and the serializer-to-video gap, so it is sized for the largest of them.
   localparam int CNT_MAX_A = (RST_PULSE_CYC > LOCK_STABLE_CYC) ? RST_PULSE_CYC : LOCK_STABLE_CYC;
   localparam int CNT_MAX   = (CNT_MAX_A > SER_TO_VID_CYC) ? CNT_MAX_A : SER_TO_VID_CYC;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam int TO_W      = $clog2(LOCK_TIMEOUT_CYC + 1);
   localparam int RETRY_W   = $clog2(MAX_RETRY + 1);

   localparam logic [CNT_W-1:0]   PULSE_LAST  = CNT_W'(RST_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [CNT_W-1:0]   S2V_LAST    = CNT_W'(SER_TO_VID_CYC - 1);
   localparam logic [TO_W-1:0]    TO_LAST     = TO_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRY - 1);

   typedef enum logic [2:0] {
      S_RST_PLL   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_REL_SER   = 3'd3,
      S_RUN       = 3'd4,
      S_FAIL      = 3'd5
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cyc_cnt;
   logic [CNT_W-1:0]   cyc_nxt;
   logic [TO_W-1:0]    to_cnt;
   logic [TO_W-1:0]    to_nxt;
   logic [RETRY_W-1:0] retry_nxt;
   logic               timeout;

   logic               pll_reset_nxt;
   logic               ser_rst_n_nxt;
   logic               vid_rst_n_nxt;
   logic               locked_nxt;
   logic               fail_nxt;

   logic               lock_meta;
   logic               lock_s;

   // Lock synchronizer: pll_lock has no timing relation to sys_clk.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_lock;
         lock_s    <= lock_meta;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_RST_PLL;
         cyc_cnt   <= '0;
         to_cnt    <= '0;
         retry_cnt <= '0;
         pll_reset <= 1'b1;
         ser_rst_n <= 1'b0;
         vid_rst_n <= 1'b0;
         locked    <= 1'b0;
         fail      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cyc_cnt   <= cyc_nxt;
         to_cnt    <= to_nxt;
         retry_cnt <= retry_nxt;
         pll_reset <= pll_reset_nxt;
         ser_rst_n <= ser_rst_n_nxt;
         vid_rst_n <= vid_rst_n_nxt;
         locked    <= locked_nxt;
         fail      <= fail_nxt;
      end
   end

   // Next-state logic and output decode.
   always_comb begin
      state_nxt = state;
      cyc_nxt   = cyc_cnt;
      to_nxt    = to_cnt;
      retry_nxt = retry_cnt;
      timeout   = (to_cnt == TO_LAST);

      if (restart) begin
         state_nxt = S_RST_PLL;
         cyc_nxt   = '0;
         retry_nxt = '0;
      end else begin
         case (state)
            S_RST_PLL: begin
               if (cyc_cnt == PULSE_LAST) begin
                  state_nxt = S_WAIT_LOCK;
                  cyc_nxt   = '0;
                  to_nxt    = '0;
               end else begin
                  cyc_nxt = cyc_cnt + 1'b1;
               end
            end

            // Timeout is checked ahead of lock so the timeout counter can
            // never run past its terminal value while it still matters.
            S_WAIT_LOCK: begin
               to_nxt = to_cnt + 1'b1;
               if (timeout) begin
                  retry_nxt = retry_cnt + 1'b1;
                  cyc_nxt   = '0;
                  state_nxt = (retry_cnt == RETRY_LAST) ? S_FAIL : S_RST_PLL;
               end else if (lock_s) begin
                  state_nxt = S_STABLE;
                  cyc_nxt   = '0;
               end
            end

            // Completion needs lock_s high on its last cycle, so testing it
            // first lets it beat a coincident timeout; a timeout in turn
            // beats a lock drop so a bouncing lock cannot dodge it.
            S_STABLE: begin
               to_nxt = to_cnt + 1'b1;
               if (lock_s && (cyc_cnt == STABLE_LAST)) begin
                  state_nxt = S_REL_SER;
                  cyc_nxt   = '0;
               end else if (timeout) begin
                  retry_nxt = retry_cnt + 1'b1;
                  cyc_nxt   = '0;
                  state_nxt = (retry_cnt == RETRY_LAST) ? S_FAIL : S_RST_PLL;
               end else if (!lock_s) begin
                  state_nxt = S_WAIT_LOCK;
                  cyc_nxt   = '0;
               end else begin
                  cyc_nxt = cyc_cnt + 1'b1;
               end
            end

            S_REL_SER: begin
               if (!lock_s) begin
                  state_nxt = S_RST_PLL;
                  cyc_nxt   = '0;
               end else if (cyc_cnt == S2V_LAST) begin
                  state_nxt = S_RUN;
                  cyc_nxt   = '0;
                  retry_nxt = '0;
               end else begin
                  cyc_nxt = cyc_cnt + 1'b1;
               end
            end

            // Lock loss is not a timeout, so retry_cnt is left alone.
            S_RUN: begin
               if (!lock_s) begin
                  state_nxt = S_RST_PLL;
                  cyc_nxt   = '0;
               end
            end

            S_FAIL: begin
               state_nxt = S_FAIL;
            end

            default: begin
               state_nxt = S_RST_PLL;
               cyc_nxt   = '0;
            end
         endcase
      end

      pll_reset_nxt = (state_nxt == S_RST_PLL) || (state_nxt == S_FAIL);
      ser_rst_n_nxt = (state_nxt == S_REL_SER) || (state_nxt == S_RUN);
      vid_rst_n_nxt = (state_nxt == S_RUN);
      locked_nxt    = (state_nxt == S_RUN);
      fail_nxt      = (state_nxt == S_FAIL);
   end

endmodule
